// File: rtl/vga_frame_reader_pkg.sv
// ----------------------------------------------------------------------------
// vga_defs : shared definitions for the VGA scan-out path.
//   - 640x480@60 Hz timing constants and derived line/frame totals
//   - 3-bit {R,G,B} colour codes used by the CPU VGA opcodes
//   - framebuffer address packing helper ({row[7:0], col[7:0]})
// No ports (package).
// ----------------------------------------------------------------------------
package vga_defs;

   // Horizontal timing in pixels.
   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   // Vertical timing in lines.
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   // Counter width: enough for 0..799 and 0..524.
   localparam int CNT_W = 10;

   // Colour codes, bit order {R,G,B}.
   localparam logic [2:0] COLOR_BLACK   = 3'b000;
   localparam logic [2:0] COLOR_BLUE    = 3'b001;
   localparam logic [2:0] COLOR_GREEN   = 3'b010;
   localparam logic [2:0] COLOR_CYAN    = 3'b011;
   localparam logic [2:0] COLOR_RED     = 3'b100;
   localparam logic [2:0] COLOR_MAGENTA = 3'b101;
   localparam logic [2:0] COLOR_YELLOW  = 3'b110;
   localparam logic [2:0] COLOR_WHITE   = 3'b111;

   // Framebuffer address: row in the high byte, column in the low byte.
   function automatic logic [15:0] pack_addr(input logic [7:0] col, input logic [7:0] row);
      return {row, col};
   endfunction

endpackage

// File: rtl/vga_frame_reader_timing_counter.sv
// ----------------------------------------------------------------------------
// vga_timing_counter : 25 MHz pixel enable plus horizontal/vertical counters.
// Ports:
//   clk     in   50 MHz system clock
//   rst     in   asynchronous active-high reset
//   pix_en  out  pixel enable, toggles every clk, 0 on first clk after reset
//   hcount  out  pixel within line, 0..H_TOTAL-1
//   vcount  out  line within frame, 0..V_TOTAL-1
// ----------------------------------------------------------------------------
module vga_timing_counter
   import vga_defs::*;
#(
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int V_TOTAL = VGA_V_TOTAL
)(
   input  logic             clk,
   input  logic             rst,
   output logic             pix_en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Divide-by-two pixel enable; low on the first clock after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
      end
   end

   // Raster counters: hcount wraps each line and carries into vcount.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount <= {CNT_W{1'b0}};
         vcount <= {CNT_W{1'b0}};
      end else if (pix_en) begin
         if (hcount == H_LAST) begin
            hcount <= {CNT_W{1'b0}};
            if (vcount == V_LAST) begin
               vcount <= {CNT_W{1'b0}};
            end else begin
               vcount <= vcount + 10'd1;
            end
         end else begin
            hcount <= hcount + 10'd1;
         end
      end
   end

endmodule

// File: rtl/vga_frame_reader.sv
// ----------------------------------------------------------------------------
// vga_frame_reader : framebuffer scan-out producing 640x480@60 Hz VGA.
// A FB_W x FB_H framebuffer window is mapped at the screen origin; the rest
// of the visible area shows BG_COLOR, blanking is black.
// Optional build macro VGA_BORDER_EN: draws a white one-pixel frame on
// column FB_W and row FB_H just outside the window.
// Ports:
//   Clock         in   50 MHz system clock
//   Reset         in   asynchronous active-high reset
//   oReadAddress  out  framebuffer read address {row[7:0], col[7:0]}
//   oReadEnable   out  current pixel lies inside the window
//   iReadData     in   framebuffer data {R,G,B}, valid one Clock after address
//   oVGA_R/G/B    out  registered colour
//   oHSync        out  horizontal sync, active low
//   oVSync        out  vertical sync, active low
//   oFrameStart   out  one-Clock pulse when pixel (0,0) is presented
// ----------------------------------------------------------------------------
module vga_frame_reader
   import vga_defs::*;
#(
   parameter int         H_VISIBLE = VGA_H_VISIBLE,
   parameter int         H_FRONT   = VGA_H_FRONT,
   parameter int         H_SYNC    = VGA_H_SYNC,
   parameter int         H_BACK    = VGA_H_BACK,
   parameter int         V_VISIBLE = VGA_V_VISIBLE,
   parameter int         V_FRONT   = VGA_V_FRONT,
   parameter int         V_SYNC    = VGA_V_SYNC,
   parameter int         V_BACK    = VGA_V_BACK,
   parameter int         FB_W      = 256,
   parameter int         FB_H      = 256,
   parameter logic [2:0] BG_COLOR  = COLOR_BLACK
)(
   input  logic        Clock,
   input  logic        Reset,
   output logic [15:0] oReadAddress,
   output logic        oReadEnable,
   input  logic [2:0]  iReadData,
   output logic        oVGA_R,
   output logic        oVGA_G,
   output logic        oVGA_B,
   output logic        oHSync,
   output logic        oVSync,
   output logic        oFrameStart
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] WIN_W     = CNT_W'(FB_W);
   localparam logic [CNT_W-1:0] WIN_H     = CNT_W'(FB_H);

   logic             pix_en;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;

   logic             visible;
   logic             on_border;
   logic             hsync_next;
   logic             vsync_next;
   logic [2:0]       color_next;

   vga_timing_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_timing (
      .clk    (Clock),
      .rst    (Reset),
      .pix_en (pix_en),
      .hcount (hcount),
      .vcount (vcount)
   );

   // Address stage: held for the whole two-Clock pixel period, so the
   // framebuffer's one-Clock read latency lands before the next enable edge.
   always_comb begin
      oReadAddress = pack_addr(hcount[7:0], vcount[7:0]);
      oReadEnable  = (hcount < WIN_W) && (vcount < WIN_H);
   end

`ifdef VGA_BORDER_EN
   // Border column FB_W and border row FB_H, limited to the window corner.
   always_comb begin
      on_border = ((hcount == WIN_W) && (vcount <= WIN_H)) ||
                  ((vcount == WIN_H) && (hcount <= WIN_W));
   end
`else
   assign on_border = 1'b0;
`endif

   // Next-pixel sync and colour decode from the current counter values.
   always_comb begin
      visible    = (hcount < H_VIS_END) && (vcount < V_VIS_END);
      hsync_next = ~((hcount >= HS_START) && (hcount < HS_END));
      vsync_next = ~((vcount >= VS_START) && (vcount < VS_END));
      color_next = COLOR_BLACK;
      if (!visible) begin
         color_next = COLOR_BLACK;
      end else if (oReadEnable) begin
         color_next = iReadData;
      end else if (on_border) begin
         color_next = COLOR_WHITE;
      end else begin
         color_next = BG_COLOR;
      end
   end

   // Output stage: sync and colour registered together so they stay aligned.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oVGA_R <= 1'b0;
         oVGA_G <= 1'b0;
         oVGA_B <= 1'b0;
         oHSync <= 1'b1;
         oVSync <= 1'b1;
      end else if (pix_en) begin
         {oVGA_R, oVGA_G, oVGA_B} <= color_next;
         oHSync <= hsync_next;
         oVSync <= vsync_next;
      end
   end

   // Frame marker: set on the edge registering (0,0); the following edge
   // always has pix_en low, which clears it after exactly one Clock.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oFrameStart <= 1'b0;
      end else begin
         oFrameStart <= pix_en && (hcount == 10'd0) && (vcount == 10'd0);
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// ----------------------------------------------------------------------------
// Testbench for vga_frame_reader. Full 800-pixel lines; the vertical timing
// and window height are shrunk so that whole frames fit in a short run.
// A random framebuffer image drives iReadData; expected pixels come from a
// raster-arithmetic reference model and are checked through a scoreboard.
// ----------------------------------------------------------------------------
module tb_vga_frame_reader;

   localparam int HV = 640, HF = 16, HS = 96, HB = 48;
   localparam int VV = 14, VF = 2, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FBW = 256, FBH = 10;
   localparam logic [2:0] BG = 3'b001;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] oReadAddress;
   logic        oReadEnable;
   logic [2:0]  iReadData;
   logic        oVGA_R, oVGA_G, oVGA_B, oHSync, oVSync, oFrameStart;

   typedef struct packed {
      logic [2:0] rgb;
      logic       hs;
      logic       vs;
      logic       fs;
   } exp_t;

   logic [2:0]  mem [0:65535];
   exp_t        exp_q[$];
   exp_t        cur;
   int          k;
   int          checks = 0;
   int          failures = 0;
   int          vs_runs = 0;

   vga_frame_reader #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .FB_W(FBW), .FB_H(FBH), .BG_COLOR(BG)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .oReadAddress(oReadAddress), .oReadEnable(oReadEnable), .iReadData(iReadData),
      .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
      .oHSync(oHSync), .oVSync(oVSync), .oFrameStart(oFrameStart)
   );

   always #10 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at t=%0t k=%0d: actual=%0h required=%0h", name, $time, k, act, req);
      end
   endtask

   // Reference: pixel n of the raster (n counted from the scan start).
   function automatic exp_t model(input int n);
      exp_t r;
      int   p, h, v;
      logic vis, en, bord;
      logic [15:0] a;
      p = n % (HT * VT);
      h = p % HT;
      v = p / HT;
      a = {v[7:0], h[7:0]};
      vis  = (h < HV) && (v < VV);
      en   = (h < FBW) && (v < FBH);
      bord = 1'b0;
`ifdef VGA_BORDER_EN
      bord = ((h == FBW) && (v <= FBH)) || ((v == FBH) && (h <= FBW));
`endif
      if (!vis)      r.rgb = 3'b000;
      else if (en)   r.rgb = mem[a];
      else if (bord) r.rgb = 3'b111;
      else           r.rgb = BG;
      r.hs = !((h >= HV + HF) && (h < HV + HF + HS));
      r.vs = !((v >= VV + VF) && (v < VV + VF + VS));
      r.fs = (h == 0) && (v == 0);
      return r;
   endfunction

   // Clock edges since reset release.
   always @(posedge Clock or posedge Reset) begin
      if (Reset) k <= 0;
      else       k <= k + 1;
   end

   // Framebuffer model: garbage in the first Clock after an address change,
   // the stored word once the address has been stable for one Clock.
   initial begin
      logic [15:0] prev_addr;
      iReadData = 3'b000;
      prev_addr = 16'h0000;
      forever begin
         @(negedge Clock);
         if (oReadAddress == prev_addr) iReadData = mem[oReadAddress];
         else                           iReadData = 3'($urandom);
         prev_addr = oReadAddress;
      end
   end

   // Producer: while the counters hold pixel n, check the address stage and
   // push the expected registered output for that pixel.
   initial begin
      forever begin
         @(negedge Clock);
         if (!Reset && (k >= 1) && (k % 2 == 1)) begin
            int n, p, h, v;
            logic [15:0] ea;
            n = (k - 1) / 2;
            p = n % (HT * VT);
            h = p % HT;
            v = p / HT;
            ea = {v[7:0], h[7:0]};
            check("read_address", oReadAddress, ea);
            check("read_enable", oReadEnable, (h < FBW) && (v < FBH));
            exp_q.push_back(model(n));
         end
      end
   end

   // Monitor: each pixel-enable edge presents a new pixel; the following
   // Clock must hold it with oFrameStart low.
   initial begin
      forever begin
         @(negedge Clock);
         if (!Reset && (k >= 2)) begin
            if (k % 2 == 0) begin
               if (exp_q.size() == 0) begin
                  check("scoreboard_nonempty", 32'd0, 32'd1);
               end else begin
                  cur = exp_q.pop_front();
                  check("rgb", {oVGA_R, oVGA_G, oVGA_B}, cur.rgb);
                  check("hsync", oHSync, cur.hs);
                  check("vsync", oVSync, cur.vs);
                  check("frame_start", oFrameStart, cur.fs);
               end
            end else begin
               check("rgb_hold", {oVGA_R, oVGA_G, oVGA_B}, cur.rgb);
               check("hsync_hold", oHSync, cur.hs);
               check("vsync_hold", oVSync, cur.vs);
               check("frame_start_pulse", oFrameStart, 1'b0);
            end
         end
      end
   end

   // Sync pulse widths and periods measured in Clocks.
   initial begin
      int t, hs_low, vs_low, hs_fall, vs_fall;
      logic prev_hs, prev_vs;
      t = 0; hs_low = 0; vs_low = 0; hs_fall = -1; vs_fall = -1;
      prev_hs = 1'b1; prev_vs = 1'b1;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            t = 0; hs_low = 0; vs_low = 0; hs_fall = -1; vs_fall = -1;
            prev_hs = 1'b1; prev_vs = 1'b1;
         end else begin
            t++;
            if (!oHSync) begin
               if (prev_hs) begin
                  if (hs_fall >= 0) check("hsync_period", t - hs_fall, 2 * HT);
                  hs_fall = t;
               end
               hs_low++;
            end else begin
               if (!prev_hs) check("hsync_width", hs_low, 2 * HS);
               hs_low = 0;
            end
            if (!oVSync) begin
               if (prev_vs) begin
                  if (vs_fall >= 0) check("vsync_period", t - vs_fall, 2 * HT * VT);
                  vs_fall = t;
               end
               vs_low++;
            end else begin
               if (!prev_vs) begin
                  check("vsync_width", vs_low, 2 * HT * VS);
                  vs_runs++;
               end
               vs_low = 0;
            end
            prev_hs = oHSync;
            prev_vs = oVSync;
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_rgb"}, {oVGA_R, oVGA_G, oVGA_B}, 3'b000);
      check({tag, "_hsync"}, oHSync, 1'b1);
      check({tag, "_vsync"}, oVSync, 1'b1);
      check({tag, "_frame_start"}, oFrameStart, 1'b0);
      check({tag, "_address"}, oReadAddress, 16'h0000);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 3'($urandom);
      mem[16'h0305] = 3'b010;   // (5,3): green inside the window
      mem[16'h0A2C] = 3'b111;   // (300,10): outside the window, must be ignored
      mem[16'h02BC] = 3'b111;   // (700,2): horizontal blanking

      Reset = 1'b1;
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      check_reset_values("por");
      Reset = 1'b0;

      // Run into the middle of a line, then reset asynchronously.
      repeat (5500) @(posedge Clock);
      #3 Reset = 1'b1;
      #1 check_reset_values("async_reset");
      repeat (3) @(negedge Clock);
      check_reset_values("reset_held");
      exp_q.delete();
      Reset = 1'b0;

      // Two full frames plus a few lines after the restart.
      repeat (66000) @(posedge Clock);
      @(negedge Clock);
      check("vsync_pulses_seen", vs_runs >= 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
